lmsm_uop_sequencer: RTL and testbench
=====================================

// Module: lmsm_uop_sequencer
// PURPOSE
//  Clocked, N-wide successor to the combinational LM/SM splitter in the decode stage.
//  Accepts one instruction per handshake. LM (0110) / SM (0111) with a non-empty
//  mask is cracked into a sequence of LW (0100) / SW (0101) uops, up to N_UOP per cycle.
//  Any other instruction passes through on lane 0. Sits between fetch buffer and rename.
// PARAMETERS
//  N_UOP     2  uops emitted per cycle; legal 1..8
//  IMM_STEP  2  imm6 increment between consecutive uops of one LM/SM
//  START_OFF 0  imm6 of the first uop of every LM/SM
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  flush      in   1        sync kill of held instruction and all pending uops
//  in_valid   in   1        in_instr valid
//  in_ready   out  1        sequencer can take in_instr this cycle
//  in_instr   in   16       raw instr: [15:12] opcode, [11:9] base reg, [7:0] mask
//  out_valid  out  N_UOP    per-lane valid; always contiguous from lane 0
//  out_uop    out  16*N_UOP lane j at [16j+15:16j]
//  out_last   out  1        current group ends the held instruction
//  out_ready  in   1        consumer takes the whole group (all-or-nothing)
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; out_valid=0; out_uop=0; out_last=0; held mask/offset=0.
//  - States: IDLE, PASS, SPLIT.
//    - IDLE: in_ready=1.
//      - Accept LM/SM with mask!=0 -> SPLIT; load mask, base, opcode; offset=START_OFF.
//      - Accept LM/SM with mask==0 -> stay IDLE; no output; consumed.
//      - Accept other instr -> PASS; instr held.
//    - PASS: lane0 = held instr; out_valid=1 (lane0 only); out_last=1.
//    - SPLIT: lane j = j-th lowest set bit b of remaining mask.
//      - uop = {op[3:2],1'b0,op[0], 3'(7-b), base, offset + j*IMM_STEP}.
//      - out_valid = lanes with a bit; out_last = (popcount(remaining) <= N_UOP).
//  - Group fire = any out_valid && out_ready:
//    - SPLIT: clear emitted bits; offset += count*IMM_STEP.
//    - SPLIT or PASS: if out_last -> IDLE.
//  - Back-to-back: in_ready is also 1 in the cycle a group with out_last fires.
//    - The new instr is loaded in that same edge (no bubble).
//  - Latency: instr accepted at edge t, first group visible after edge t.
//    - One cycle per group while out_ready=1.
//    - LM/SM of popcount P takes ceil(P/N_UOP) cycles.
//  - out_valid/out_uop stable while out_valid && !out_ready.
//  - Arithmetic: imm6 modulo 64, wraps silently (START_OFF=60, STEP=2 -> 60,62,0,...).
//  - flush: highest priority.
//    - Forces in_ready=0 that cycle; next state IDLE; out_valid=0 next cycle.
//    - A simultaneous fire/accept is discarded.
//  - Async reset mid-SPLIT drops remaining uops; no partial state survives.
//  - Invalid lanes drive out_uop=0.
// CONFIGURATION
//  - LMSM_STATS_EN defined: adds outputs stat_lmsm (32b), stat_uops (32b),
//    stat_empty (16b), reset 0, saturating.
//    - stat_lmsm counts accepted LM/SM.
//    - stat_uops counts fired LW/SW uops.
//    - stat_empty counts mask==0 drops.
//  - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package lmsm_pkg: opcode constants OP_LM, OP_SM, OP_LW, OP_SW;
//    field positions OPC, RA, MASK; state enum; uop16 pack function.
//  - Sub-module lmsm_find_lowest (mask in -> onehot, index, found).
//    - Cascaded N_UOP times, each stage masking out the previous pick.
// TESTING
//  - N=2, LM 0x6485 (R2, mask 1000_0101), out_ready=1:
//    - cyc1 lanes 0x4E80, 0x4A82, last=0.
//    - cyc2 lane0 0x4084, valid=01, last=1.
//  - SM mask 0xFF, N=2, out_ready low 3 cycles mid-sequence:
//    - Output held stable.
//    - 4 groups total; regs 7..0; imm 0..14; busy drops after last fire.
//  - Non-LMSM 0x1234 followed immediately by LM mask 0x01:
//    - 0x1234 on lane0 with last=1.
//    - LM accepted the same edge; next cycle 0x4E80-form uop, no bubble.
//  - LM mask 0x00:
//    - in_ready stays 1; no out_valid ever.
//    - stat_empty +1 (LMSM_STATS_EN).
//  - flush in cycle 2 of mask 0xFF, N=1: out_valid=0 next cycle, state IDLE, in_ready=1.
//    - Also assert rst_n low mid-SPLIT: all outputs 0 asynchronously.
//  - START_OFF=60, N=4, mask 0x0F: imm 60,62,0,2 in one group, last=1.

Source files
------------

// File: rtl/lmsm_pkg.sv
// lmsm_pkg: opcode constants, instruction field positions, sequencer state
// encoding and the LW/SW uop packing helper shared by the LM/SM sequencer.
package lmsm_pkg;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;
    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;

    // Raw instruction fields: [15:12] opcode, [11:9] base reg, [7:0] mask
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RA_HI   = 11;
    localparam int RA_LO   = 9;
    localparam int MASK_HI = 7;
    localparam int MASK_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_SPLIT = 2'd2
    } state_t;

    // Mask bit b maps to register 7-b; SM cracks into SW, LM into LW.
    function automatic logic [15:0] uop16(input logic [3:0] op, input logic [2:0] bitpos,
                                          input logic [2:0] base, input logic [5:0] imm);
        logic [3:0] uop_op;
        uop_op = (op == OP_SM) ? OP_SW : OP_LW;
        return {uop_op, 3'd7 - bitpos, base, imm};
    endfunction

endpackage

// File: rtl/lmsm_uop_sequencer_if.sv
// lmsm_uop_sequencer_if: instruction-in / uop-group-out handshake bundle.
// slave = sequencer side, master = fetch buffer + rename side.
interface lmsm_uop_sequencer_if #(
    parameter int N_UOP = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [15:0]            in_instr;
    logic [N_UOP-1:0]       out_valid;
    logic [N_UOP-1:0][15:0] out_uop;
    logic                   out_last;
    logic                   out_ready;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_uop, out_last
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_uop, out_last
    );
endinterface

// File: rtl/lmsm_find_lowest.sv
// lmsm_find_lowest: picks the lowest set bit of an 8-bit register mask.
module lmsm_find_lowest (
    input  logic [7:0] mask,
    output logic [7:0] onehot,
    output logic [2:0] idx,
    output logic       found
);
    // Isolate lowest set bit and encode its position
    always_comb begin
        onehot = mask & (~mask + 8'd1);
        found  = |mask;
        idx    = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
    end
endmodule

// File: rtl/lmsm_uop_sequencer.sv
// lmsm_uop_sequencer: cracks LM/SM into up to N_UOP LW/SW uops per cycle,
// passes any other instruction through on lane 0.
// Optional: define LMSM_STATS_EN to add saturating stat_lmsm/stat_uops/stat_empty.
module lmsm_uop_sequencer
    import lmsm_pkg::*;
#(
    parameter int N_UOP     = 2,
    parameter int IMM_STEP  = 2,
    parameter int START_OFF = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    lmsm_uop_sequencer_if.slave  bus,
    output logic                 busy
`ifdef LMSM_STATS_EN
    ,
    output logic [31:0]          stat_lmsm,
    output logic [31:0]          stat_uops,
    output logic [15:0]          stat_empty
`endif
);
    state_t                 state_q, state_d;
    logic [7:0]             mask_q, mask_d;     // bits still to be emitted
    logic [7:0]             grp_q, grp_d;       // bits carried by the visible group
    logic [2:0]             base_q, base_d;
    logic [3:0]             op_q, op_d;
    logic [5:0]             off_q, off_d;
    logic [15:0]            instr_q, instr_d;
    logic [N_UOP-1:0]       out_valid_q, out_valid_d;
    logic [N_UOP-1:0][15:0] out_uop_q, out_uop_d;
    logic                   out_last_q, out_last_d;

    logic                   fire, in_ready, accept, in_is_lmsm, in_empty;
    logic [3:0]             grp_cnt;
    logic [N_UOP-1:0]       lane_vld;
    logic [N_UOP-1:0][15:0] lane_uop;
    logic [7:0]             rem_last;

    assign fire       = (|out_valid_q) && bus.out_ready;
    assign in_ready   = !flush && (state_q == ST_IDLE || (fire && out_last_q));
    assign accept     = bus.in_valid && in_ready;
    assign in_is_lmsm = (bus.in_instr[OPC_HI:OPC_LO] == OP_LM) ||
                        (bus.in_instr[OPC_HI:OPC_LO] == OP_SM);
    assign in_empty   = (bus.in_instr[MASK_HI:MASK_LO] == 8'h00);
    assign grp_cnt    = 4'($countones(out_valid_q));

    // Next-state: retire the fired group, then load any accepted instruction
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        base_d  = base_q;
        op_d    = op_q;
        off_d   = off_q;
        instr_d = instr_q;
        if (flush) begin
            state_d = ST_IDLE;
            mask_d  = '0;
            off_d   = '0;
        end else begin
            if (fire) begin
                if (state_q == ST_SPLIT) begin
                    mask_d = mask_q & ~grp_q;
                    off_d  = off_q + 6'(int'(grp_cnt) * IMM_STEP);
                end
                if (out_last_q) state_d = ST_IDLE;
            end
            if (accept) begin
                if (in_is_lmsm) begin
                    if (!in_empty) begin
                        state_d = ST_SPLIT;
                        mask_d  = bus.in_instr[MASK_HI:MASK_LO];
                        base_d  = bus.in_instr[RA_HI:RA_LO];
                        op_d    = bus.in_instr[OPC_HI:OPC_LO];
                        off_d   = 6'(START_OFF);
                    end
                end else begin
                    state_d = ST_PASS;
                    instr_d = bus.in_instr;
                end
            end
        end
    end

    // Cascade of lowest-bit pickers over the next remaining mask, one per lane
    for (genvar j = 0; j < N_UOP; j++) begin : g_lane
        logic [7:0] src, oh, rest;
        logic [2:0] idx;
        logic       found;
        if (j == 0) begin : g_head
            assign src = mask_d;
        end else begin : g_tail
            assign src = g_lane[j-1].rest;
        end
        lmsm_find_lowest u_find (.mask(src), .onehot(oh), .idx(idx), .found(found));
        assign rest        = src & ~oh;
        assign lane_vld[j] = found;
        assign lane_uop[j] = found ? uop16(op_d, idx, base_d, off_d + 6'(j * IMM_STEP)) : 16'h0;
    end
    assign rem_last = g_lane[N_UOP-1].rest;

    // Next output group, decoded from next state so outputs leave a flop
    always_comb begin
        out_valid_d = '0;
        out_uop_d   = '0;
        out_last_d  = 1'b0;
        grp_d       = '0;
        case (state_d)
            ST_PASS: begin
                out_valid_d[0] = 1'b1;
                out_uop_d[0]   = instr_d;
                out_last_d     = 1'b1;
            end
            ST_SPLIT: begin
                out_valid_d = lane_vld;
                out_uop_d   = lane_uop;
                out_last_d  = (rem_last == 8'h00);
                grp_d       = mask_d & ~rem_last;
            end
            default: ;
        endcase
    end

    // FSM state, held instruction context and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            grp_q       <= '0;
            base_q      <= '0;
            op_q        <= '0;
            off_q       <= '0;
            instr_q     <= '0;
            out_valid_q <= '0;
            out_uop_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            grp_q       <= grp_d;
            base_q      <= base_d;
            op_q        <= op_d;
            off_q       <= off_d;
            instr_q     <= instr_d;
            out_valid_q <= out_valid_d;
            out_uop_q   <= out_uop_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_uop   = out_uop_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != ST_IDLE);

`ifdef LMSM_STATS_EN
    logic [31:0] stat_lmsm_q, stat_lmsm_d;
    logic [31:0] stat_uops_q, stat_uops_d;
    logic [15:0] stat_empty_q, stat_empty_d;
    logic [32:0] uops_sum;

    // Saturating event counters; flushed fires are not counted
    always_comb begin
        stat_lmsm_d  = stat_lmsm_q;
        stat_uops_d  = stat_uops_q;
        stat_empty_d = stat_empty_q;
        uops_sum     = {1'b0, stat_uops_q} + 33'(grp_cnt);
        if (accept && in_is_lmsm && stat_lmsm_q != '1) stat_lmsm_d = stat_lmsm_q + 32'd1;
        if (accept && in_is_lmsm && in_empty && stat_empty_q != '1)
            stat_empty_d = stat_empty_q + 16'd1;
        if (fire && !flush && state_q == ST_SPLIT)
            stat_uops_d = uops_sum[32] ? '1 : uops_sum[31:0];
    end

    // Statistic registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lmsm_q  <= '0;
            stat_uops_q  <= '0;
            stat_empty_q <= '0;
        end else begin
            stat_lmsm_q  <= stat_lmsm_d;
            stat_uops_q  <= stat_uops_d;
            stat_empty_q <= stat_empty_d;
        end
    end

    assign stat_lmsm  = stat_lmsm_q;
    assign stat_uops  = stat_uops_q;
    assign stat_empty = stat_empty_q;
`endif

endmodule

// File: tb/tb_lmsm_uop_sequencer.sv
// tb_lmsm_uop_sequencer: directed + random checks of the LM/SM sequencer
// against a queue-of-groups reference model. Honours LMSM_STATS_EN.
module tb_lmsm_uop_sequencer;

    localparam int NA   = 2;
    localparam int STEP = 2;
    localparam int OFFA = 0;

    typedef struct packed {
        logic [3:0]       n;
        logic [7:0][15:0] u;
        logic             last;
    } grp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    logic busy_a, busy_b;
    int   n_chk = 0;
    int   n_err = 0;
    grp_t q[$];

    always #5 clk = ~clk;

    lmsm_uop_sequencer_if #(.N_UOP(NA)) bus_a ();
    lmsm_uop_sequencer_if #(.N_UOP(4))  bus_b ();

`ifdef LMSM_STATS_EN
    logic [31:0] st_lmsm_a, st_uops_a, st_lmsm_b, st_uops_b;
    logic [15:0] st_empty_a, st_empty_b;
`endif

    lmsm_uop_sequencer #(.N_UOP(NA), .IMM_STEP(STEP), .START_OFF(OFFA)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a), .busy(busy_a)
`ifdef LMSM_STATS_EN
        , .stat_lmsm(st_lmsm_a), .stat_uops(st_uops_a), .stat_empty(st_empty_a)
`endif
    );

    lmsm_uop_sequencer #(.N_UOP(4), .IMM_STEP(2), .START_OFF(60)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b), .busy(busy_b)
`ifdef LMSM_STATS_EN
        , .stat_lmsm(st_lmsm_b), .stat_uops(st_uops_b), .stat_empty(st_empty_b)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: list the set mask bits low to high, number them k, chunk by NA
    task automatic push_instr(input logic [15:0] ins);
        int   op, p, k;
        grp_t g;
        op = int'(ins[15:12]);
        g  = '0;
        if (op == 6 || op == 7) begin
            p = $countones(ins[7:0]);
            k = 0;
            for (int b = 0; b < 8; b++) begin
                if (ins[b]) begin
                    g.u[g.n] = 16'((op - 2) * 4096 + (7 - b) * 512 + int'(ins[11:9]) * 64
                                   + ((OFFA + k * STEP) % 64));
                    g.n = g.n + 4'd1;
                    k++;
                    if (int'(g.n) == NA || k == p) begin
                        g.last = (k == p);
                        q.push_back(g);
                        g = '0;
                    end
                end
            end
        end else begin
            g.n    = 4'd1;
            g.u[0] = ins;
            g.last = 1'b1;
            q.push_back(g);
        end
    endtask

    task automatic check_out();
        logic [NA-1:0]       ev;
        logic [NA-1:0][15:0] eu;
        logic                el;
        ev = '0; eu = '0; el = 1'b0;
        if (q.size() != 0) begin
            ev = NA'((1 << int'(q[0].n)) - 1);
            eu = q[0].u[NA-1:0];
            el = q[0].last;
        end
        chk("out_valid", bus_a.out_valid, ev);
        chk("out_uop", bus_a.out_uop, eu);
        chk("out_last", bus_a.out_last, el);
        chk("busy", busy_a, q.size() != 0);
    endtask

    // One clock of DUT A: drive, check in_ready, clock, advance model, check outputs
    task automatic step(input logic iv, input logic [15:0] ins, input logic ordy, input logic fl);
        logic fire, exp_rdy;
        bus_a.in_valid  = iv;
        bus_a.in_instr  = ins;
        bus_a.out_ready = ordy;
        flush_a         = fl;
        #1;
        fire    = (q.size() != 0) && ordy;
        exp_rdy = !fl && ((q.size() == 0) || (fire && q[0].last));
        chk("in_ready", bus_a.in_ready, exp_rdy);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (fire) void'(q.pop_front());
            if (iv && exp_rdy) push_instr(ins);
        end
        #1;
        check_out();
    endtask

    initial begin
        logic [15:0] ins;
        bus_a.in_valid = 1'b0; bus_a.in_instr = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_instr = '0; bus_b.out_ready = 1'b0;

        // Reset state
        #12;
        check_out();
        chk("b_valid_rst", bus_b.out_valid, 4'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_out();

        // LM 0x6485: two groups
        step(1'b1, 16'h6485, 1'b1, 1'b0);
        chk("lm1_uop", bus_a.out_uop, 32'h4A82_4E80);
        chk("lm1_last", bus_a.out_last, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("lm2_uop", bus_a.out_uop, 32'h0000_4084);
        chk("lm2_valid", bus_a.out_valid, 2'b01);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // SM 0xFF with a 3-cycle stall mid-sequence
        step(1'b1, 16'h72FF, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("sm_idle", busy_a, 1'b0);

        // Pass-through followed by back-to-back LM
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("pass_uop", bus_a.out_uop[0], 16'h1234);
        step(1'b1, 16'h6401, 1'b1, 1'b0);
        chk("b2b_uop", bus_a.out_uop[0], 16'h4E80);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Empty LM is consumed silently
        step(1'b1, 16'h6400, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
`ifdef LMSM_STATS_EN
        chk("stat_empty", st_empty_a, 16'd1);
        chk("stat_uops", st_uops_a, 32'd12);
`endif

        // Flush mid-SPLIT
        step(1'b1, 16'h72FF, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Async reset mid-SPLIT
        step(1'b1, 16'h64FF, 1'b0, 1'b0);
        bus_a.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("arst_valid", bus_a.out_valid, 2'b00);
        chk("arst_uop", bus_a.out_uop, 32'h0);
        chk("arst_last", bus_a.out_last, 1'b0);
        chk("arst_busy", busy_a, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_out();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: ins = {4'h6, 4'($urandom), 8'($urandom)};
                1: ins = {4'h7, 4'($urandom), 8'($urandom)};
                2: ins = 16'($urandom);
                default: ins = {3'b011, 1'($urandom), 4'($urandom), 8'h00};
            endcase
            step(1'($urandom), ins, ($urandom % 4) != 0, ($urandom % 25) == 0);
        end

        // N=4, START_OFF=60: imm wraps inside one group
        chk("b_rdy", bus_b.in_ready, 1'b1);
        bus_b.in_valid = 1'b1; bus_b.in_instr = 16'h600F; bus_b.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        chk("b_valid", bus_b.out_valid, 4'hF);
        chk("b_uop", bus_b.out_uop, 64'h4802_4A00_4C3E_4E3C);
        chk("b_last", bus_b.out_last, 1'b1);
        @(posedge clk); #1;
        chk("b_done", bus_b.out_valid, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
